exmem_skid_buffer: RTL and testbench
====================================

# exmem_skid_buffer

Parametrised execute-to-memory pipeline register for the multi-lane filter GPU. It carries the per-lane ALU result, two memory-direction words, store data, the destination register address and the stage control bits. Unlike a plain load-enabled register, it uses a valid/ready handshake backed by a two-entry skid buffer, so a memory-stage stall never drops an instruction. It also supports a pipeline flush and a per-lane write mask, and it gates all side-effecting control bits whenever no valid entry is presented.

## Interface
- N, 18, data width of each lane word
- LANES, 3, number of vector lanes
- WAW, 4, width of the destination register address
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- flush  in  1  drop all held entries (branch redirect)
- in_valid  in  1  upstream presents an entry
- in_ready  out  1  buffer can accept an entry this cycle
- ALUResult, memoryDirection2, memoryDirection3, writeData  in  LANES×N each  per-lane payload
- lane_mask  in  LANES  per-lane write enable captured with the entry
- WA3  in  WAW  destination register
- PCSrc, RegWrite, MemtoReg, MemWrite  in  1 each  stage control
- out_valid  out  1  head entry presented downstream
- out_ready  in  1  downstream accepts the head entry
- q1, q2, q3, writeDataO  out  LANES×N each  head-entry payload
- WA3O  out  WAW  head-entry destination
- PCSrcO, RegWriteO, MemtoRegO, MemWriteO  out  1 each  head-entry control, gated by out_valid
- mem_we  out  LANES  MemWriteO & lane_mask[i] of head entry
- occ  out  2  entries held (0, 1 or 2)

## Operation
- Storage has two entries: main (the head, which drives the outputs) and skid. Each entry holds the full payload, lane_mask, WA3 and the four control bits.
- States are EMPTY (occ=0), ONE (occ=1) and TWO (occ=2).
- push = in_valid & in_ready. pop = out_valid & out_ready.
- EMPTY: push → load main, go to ONE. Otherwise stay.
- ONE:
  - push & pop → main ← input, stay in ONE.
  - push & !pop → skid ← input, go to TWO.
  - pop & !push → EMPTY.
  - Otherwise hold.
- TWO: in_ready=0, so push cannot occur. pop → main ← skid, go to ONE. Otherwise hold.
- Priority is reset > flush > handshake.
- flush:
  - Next state is EMPTY and both entries are invalidated.
  - An input presented in the flush cycle is discarded, even if in_valid & in_ready.
  - A pop in the flush cycle counts as completed downstream.
- out_valid = (state != EMPTY).
- PCSrcO, RegWriteO, MemWriteO, MemtoRegO and mem_we are 0 whenever out_valid=0.
- q1/q2/q3/writeDataO/WA3O hold the last main contents while EMPTY. Downstream ignores them in that state.
- Payload passes through unmodified; there is no arithmetic. Lanes are independent, and lane i occupies bits [i*N +: N].
- mem_we[i] = out_valid & MemWrite(main) & lane_mask(main)[i].

## Timing
- Reset values:
  - state EMPTY, occ=0, out_valid=0, in_ready=1.
  - All payload outputs, WA3O, all control outputs and mem_we are 0.
  - The skid entry is cleared.
- in_ready is a registered output: it is 1 in EMPTY and ONE, and 0 in TWO. It has no combinational path from out_ready.
- Latency is one cycle. An entry pushed at edge k appears on the outputs after edge k, provided main was empty or popped at edge k.
- Throughput is one entry per cycle with out_ready held at 1.
- Back-to-back stall handling:
  - The first stalled cycle absorbs one extra entry into skid.
  - in_ready drops after that edge.
  - No entry is lost or duplicated, and order is preserved.
- After flush, the block is in EMPTY at the next edge with in_ready=1. It can accept a new entry in the very next cycle.
- A reset asserted mid-stall (state TWO) returns the block to its reset values at that edge. Both entries are lost.

## Test plan
- Reset with all inputs at random values → after the edge: out_valid=0, in_ready=1, occ=0, all outputs 0.
- Stream with out_ready=1: push ALUResult lanes {0x00001,0x00002,0x00003}, then {0x3FFFF,0,0x15555} in consecutive cycles → each appears one cycle later with out_valid=1, in order.
- Stall: push A, B, C with out_ready=0 → after B, occ=2 and in_ready=0, and C is held off. Raising out_ready → A, B, C delivered in order with nothing dropped.
- Flush in TWO, with in_valid=1 carrying D in the same cycle → next cycle occ=0 and out_valid=0, and D never appears. E pushed in the following cycle appears normally.
- Lane mask: push MemWrite=1, lane_mask=3'b101, RegWrite=1 → mem_we=3'b101 and RegWriteO=1 while the entry is valid. After it is popped with no new push, all control outputs and mem_we are 0.
- Reset asserted while in TWO with out_ready=0 → all outputs reach their reset values at the next edge, and the two held entries are never emitted.

Source files
------------

// File: rtl/exmem_skid_buffer_if.sv
// Execute-to-memory stage bus: upstream handshake + payload, downstream handshake + head entry.
// slave is the buffer's view; master is the surrounding pipeline's view.
interface exmem_skid_buffer_if #(
    parameter int N     = 18,
    parameter int LANES = 3,
    parameter int WAW   = 4
);
    logic                 flush;

    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*N-1:0]   ALUResult;
    logic [LANES*N-1:0]   memoryDirection2;
    logic [LANES*N-1:0]   memoryDirection3;
    logic [LANES*N-1:0]   writeData;
    logic [LANES-1:0]     lane_mask;
    logic [WAW-1:0]       WA3;
    logic                 PCSrc;
    logic                 RegWrite;
    logic                 MemtoReg;
    logic                 MemWrite;

    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   q1;
    logic [LANES*N-1:0]   q2;
    logic [LANES*N-1:0]   q3;
    logic [LANES*N-1:0]   writeDataO;
    logic [WAW-1:0]       WA3O;
    logic                 PCSrcO;
    logic                 RegWriteO;
    logic                 MemtoRegO;
    logic                 MemWriteO;
    logic [LANES-1:0]     mem_we;
    logic [1:0]           occ;

    modport slave (
        input  flush,
        input  in_valid, ALUResult, memoryDirection2, memoryDirection3, writeData,
        input  lane_mask, WA3, PCSrc, RegWrite, MemtoReg, MemWrite,
        output in_ready,
        input  out_ready,
        output out_valid, q1, q2, q3, writeDataO, WA3O,
        output PCSrcO, RegWriteO, MemtoRegO, MemWriteO, mem_we, occ
    );

    modport master (
        output flush,
        output in_valid, ALUResult, memoryDirection2, memoryDirection3, writeData,
        output lane_mask, WA3, PCSrc, RegWrite, MemtoReg, MemWrite,
        input  in_ready,
        output out_ready,
        input  out_valid, q1, q2, q3, writeDataO, WA3O,
        input  PCSrcO, RegWriteO, MemtoRegO, MemWriteO, mem_we, occ
    );
endinterface

// File: rtl/exmem_skid_buffer.sv
// Execute-to-memory pipeline register with a two-entry skid buffer, flush and per-lane store mask.
// state | meaning
// EMPTY | no entry held, outputs show stale main payload, control gated off
// ONE   | main holds the head entry, skid unused
// TWO   | main is head, skid holds the entry absorbed during a stall; in_ready low
module exmem_skid_buffer #(
    parameter int N     = 18,
    parameter int LANES = 3,
    parameter int WAW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    exmem_skid_buffer_if.slave bus
);

    typedef struct packed {
        logic [LANES*N-1:0] alu;
        logic [LANES*N-1:0] md2;
        logic [LANES*N-1:0] md3;
        logic [LANES*N-1:0] wd;
        logic [LANES-1:0]   lane_mask;
        logic [WAW-1:0]     wa3;
        logic               pcsrc;
        logic               reg_write;
        logic               memto_reg;
        logic               mem_write;
    } entry_t;

    // Encoding equals the occupancy so occ is a direct view of the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t main_q, main_nxt;
    entry_t skid_q, skid_nxt;
    entry_t in_entry;
    logic   in_ready_q;
    logic   out_valid;
    logic   push;
    logic   pop;

    assign in_entry.alu       = bus.ALUResult;
    assign in_entry.md2       = bus.memoryDirection2;
    assign in_entry.md3       = bus.memoryDirection3;
    assign in_entry.wd        = bus.writeData;
    assign in_entry.lane_mask = bus.lane_mask;
    assign in_entry.wa3       = bus.WA3;
    assign in_entry.pcsrc     = bus.PCSrc;
    assign in_entry.reg_write = bus.RegWrite;
    assign in_entry.memto_reg = bus.MemtoReg;
    assign in_entry.mem_write = bus.MemWrite;

    assign out_valid = (state != EMPTY);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // Flush only moves the state; stale payload in main stays visible while EMPTY.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_nxt  = in_entry;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_nxt = in_entry;
                    end else if (push) begin
                        skid_nxt  = in_entry;
                        state_nxt = TWO;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_nxt  = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.occ        = state;

    assign bus.q1         = main_q.alu;
    assign bus.q2         = main_q.md2;
    assign bus.q3         = main_q.md3;
    assign bus.writeDataO = main_q.wd;
    assign bus.WA3O       = main_q.wa3;

    assign bus.PCSrcO     = out_valid & main_q.pcsrc;
    assign bus.RegWriteO  = out_valid & main_q.reg_write;
    assign bus.MemtoRegO  = out_valid & main_q.memto_reg;
    assign bus.MemWriteO  = out_valid & main_q.mem_write;
    assign bus.mem_we     = {LANES{out_valid & main_q.mem_write}} & main_q.lane_mask;

endmodule

// File: tb/tb_exmem_skid_buffer.sv
// Directed bench for exmem_skid_buffer: reset, streaming, stall/skid, flush, lane mask, reset mid-stall.
module tb_exmem_skid_buffer;
    localparam int N     = 18;
    localparam int LANES = 3;
    localparam int WAW   = 4;
    localparam int W     = LANES * N;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    exmem_skid_buffer_if #(.N(N), .LANES(LANES), .WAW(WAW)) bus ();

    exmem_skid_buffer #(.N(N), .LANES(LANES), .WAW(WAW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Companion words derived from the ALU word so every payload field is distinct.
    function automatic logic [W-1:0] md2_of(input logic [W-1:0] a);
        return ~a;
    endfunction
    function automatic logic [W-1:0] md3_of(input logic [W-1:0] a);
        return {a[W/2-1:0], a[W-1:W/2]};
    endfunction
    function automatic logic [W-1:0] wd_of(input logic [W-1:0] a);
        return a ^ {LANES{18'h2AAAA}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [W-1:0] alu, input logic [WAW-1:0] wa,
                           input logic [LANES-1:0] mask, input logic [3:0] ctrl);
        bus.in_valid         = 1'b1;
        bus.ALUResult        = alu;
        bus.memoryDirection2 = md2_of(alu);
        bus.memoryDirection3 = md3_of(alu);
        bus.writeData        = wd_of(alu);
        bus.WA3              = wa;
        bus.lane_mask        = mask;
        {bus.PCSrc, bus.RegWrite, bus.MemtoReg, bus.MemWrite} = ctrl;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.flush            = 1'($urandom);
        bus.in_valid         = 1'($urandom);
        bus.out_ready        = 1'($urandom);
        bus.ALUResult        = W'({$urandom(), $urandom()});
        bus.memoryDirection2 = W'({$urandom(), $urandom()});
        bus.memoryDirection3 = W'({$urandom(), $urandom()});
        bus.writeData        = W'({$urandom(), $urandom()});
        bus.lane_mask        = LANES'($urandom);
        bus.WA3              = WAW'($urandom);
        {bus.PCSrc, bus.RegWrite, bus.MemtoReg, bus.MemWrite} = 4'($urandom);
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({bus.out_valid, bus.in_ready, bus.occ} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL reset_status: got %b expected 0100", {bus.out_valid, bus.in_ready, bus.occ});
        end
        tests_run++;
        if ({bus.q1, bus.q2, bus.q3, bus.writeDataO, bus.WA3O} !== '0) begin
            tests_failed++;
            $display("FAIL reset_payload: got q1=%h q2=%h q3=%h wd=%h wa=%h expected all 0",
                     bus.q1, bus.q2, bus.q3, bus.writeDataO, bus.WA3O);
        end
        tests_run++;
        if ({bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.mem_we} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.mem_we});
        end
        reset     = 1'b0;
        bus.flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [W-1:0] x1, x2;
        x1 = {18'h00003, 18'h00002, 18'h00001};
        x2 = {18'h15555, 18'h00000, 18'h3FFFF};
        bus.out_ready = 1'b1;
        present(x1, 4'h5, 3'b000, 4'b0100);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.occ, bus.q1, bus.q2, bus.q3, bus.writeDataO, bus.WA3O} !==
            {1'b1, 2'd1, x1, md2_of(x1), md3_of(x1), wd_of(x1), 4'h5}) begin
            tests_failed++;
            $display("FAIL stream_first: got v=%b occ=%0d q1=%h wa=%h expected v=1 occ=1 q1=%h wa=5",
                     bus.out_valid, bus.occ, bus.q1, bus.WA3O, x1);
        end
        present(x2, 4'hA, 3'b000, 4'b0010);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.occ, bus.q1, bus.q2, bus.q3, bus.writeDataO, bus.WA3O} !==
            {1'b1, 2'd1, x2, md2_of(x2), md3_of(x2), wd_of(x2), 4'hA}) begin
            tests_failed++;
            $display("FAIL stream_second: got v=%b occ=%0d q1=%h wa=%h expected v=1 occ=1 q1=%h wa=a",
                     bus.out_valid, bus.occ, bus.q1, bus.WA3O, x2);
        end
        idle();
        tick();
        tests_run++;
        if ({bus.out_valid, bus.in_ready, bus.occ, bus.q1} !== {4'b0100, x2}) begin
            tests_failed++;
            $display("FAIL stream_drain: got status=%b q1=%h expected 0100 q1=%h",
                     {bus.out_valid, bus.in_ready, bus.occ}, bus.q1, x2);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b, c;
        a = {3{18'h0000A}};
        b = {18'h00003, 18'h0002B, 18'h0001B};
        c = {3{18'h0C0C0}};
        bus.out_ready = 1'b0;
        present(a, 4'h1, 3'b111, 4'b0000);
        tick();
        tests_run++;
        if ({bus.in_ready, bus.occ, bus.q1} !== {3'b101, a}) begin
            tests_failed++;
            $display("FAIL stall_a: got rdy=%b occ=%0d q1=%h expected rdy=1 occ=1 q1=%h",
                     bus.in_ready, bus.occ, bus.q1, a);
        end
        present(b, 4'h2, 3'b010, 4'b0001);
        tick();
        tests_run++;
        if ({bus.in_ready, bus.occ, bus.q1, bus.mem_we} !== {3'b010, a, 3'b000}) begin
            tests_failed++;
            $display("FAIL stall_full: got rdy=%b occ=%0d q1=%h we=%b expected rdy=0 occ=2 q1=%h we=000",
                     bus.in_ready, bus.occ, bus.q1, bus.mem_we, a);
        end
        present(c, 4'h3, 3'b001, 4'b1000);
        tick();
        tests_run++;
        if ({bus.in_ready, bus.occ, bus.q1} !== {3'b010, a}) begin
            tests_failed++;
            $display("FAIL stall_hold: got rdy=%b occ=%0d q1=%h expected rdy=0 occ=2 q1=%h",
                     bus.in_ready, bus.occ, bus.q1, a);
        end
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({bus.in_ready, bus.occ, bus.q1, bus.q3, bus.WA3O, bus.MemWriteO, bus.mem_we} !==
            {3'b101, b, md3_of(b), 4'h2, 1'b1, 3'b010}) begin
            tests_failed++;
            $display("FAIL stall_b: got rdy=%b occ=%0d q1=%h wa=%h we=%b expected rdy=1 occ=1 q1=%h wa=2 we=010",
                     bus.in_ready, bus.occ, bus.q1, bus.WA3O, bus.mem_we, b);
        end
        tick();
        tests_run++;
        if ({bus.occ, bus.q1, bus.writeDataO, bus.WA3O, bus.PCSrcO, bus.mem_we} !==
            {2'd1, c, wd_of(c), 4'h3, 1'b1, 3'b000}) begin
            tests_failed++;
            $display("FAIL stall_c: got occ=%0d q1=%h wa=%h pc=%b we=%b expected occ=1 q1=%h wa=3 pc=1 we=000",
                     bus.occ, bus.q1, bus.WA3O, bus.PCSrcO, bus.mem_we, c);
        end
        idle();
        tick();
        tests_run++;
        if ({bus.out_valid, bus.occ, bus.q1} !== {3'b000, c}) begin
            tests_failed++;
            $display("FAIL stall_drain: got v=%b occ=%0d q1=%h expected v=0 occ=0 q1=%h",
                     bus.out_valid, bus.occ, bus.q1, c);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] d, e;
        d = {3{18'h0DDDD}};
        e = {18'h0000E, 18'h000E0, 18'h00E00};
        bus.out_ready = 1'b0;
        present({3{18'h00111}}, 4'h4, 3'b000, 4'b0000);
        tick();
        present({3{18'h00222}}, 4'h6, 3'b000, 4'b0000);
        tick();
        present(d, 4'hD, 3'b111, 4'b1111);
        bus.flush = 1'b1;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.in_ready, bus.occ, bus.RegWriteO, bus.mem_we} !== 8'b0100_0000) begin
            tests_failed++;
            $display("FAIL flush_two: got status=%b rw=%b we=%b expected 0100 rw=0 we=000",
                     {bus.out_valid, bus.in_ready, bus.occ}, bus.RegWriteO, bus.mem_we);
        end
        bus.flush = 1'b0;
        present(e, 4'hE, 3'b000, 4'b0100);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.occ, bus.q1, bus.WA3O} !== {3'b101, e, 4'hE}) begin
            tests_failed++;
            $display("FAIL flush_after: got v=%b occ=%0d q1=%h wa=%h expected v=1 occ=1 q1=%h wa=e",
                     bus.out_valid, bus.occ, bus.q1, bus.WA3O, e);
        end
        // Flush while ONE with an accepted-looking push: the push must be dropped.
        present(d, 4'hD, 3'b111, 4'b1111);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle();
        tick();
        tests_run++;
        if ({bus.out_valid, bus.in_ready, bus.occ, bus.q1} !== {4'b0100, e}) begin
            tests_failed++;
            $display("FAIL flush_one: got status=%b q1=%h expected 0100 q1=%h",
                     {bus.out_valid, bus.in_ready, bus.occ}, bus.q1, e);
        end
    endtask

    task automatic test_lane_mask();
        bus.out_ready = 1'b0;
        present({3{18'h12345}}, 4'h9, 3'b101, 4'b0101);
        tick();
        idle();
        tests_run++;
        if ({bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.mem_we} !== 7'b0101_101) begin
            tests_failed++;
            $display("FAIL mask_valid: got %b expected 0101101",
                     {bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.mem_we});
        end
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO, bus.mem_we, bus.WA3O} !==
            {8'b0, 4'h9}) begin
            tests_failed++;
            $display("FAIL mask_popped: got v=%b ctrl=%b we=%b wa=%h expected v=0 ctrl=0000 we=000 wa=9",
                     bus.out_valid, {bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO, bus.MemWriteO},
                     bus.mem_we, bus.WA3O);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        present({3{18'h3AAAA}}, 4'hF, 3'b111, 4'b1111);
        tick();
        present({3{18'h3BBBB}}, 4'h7, 3'b011, 4'b1111);
        tick();
        tests_run++;
        if ({bus.in_ready, bus.occ} !== 3'b010) begin
            tests_failed++;
            $display("FAIL rst_stall_pre: got rdy=%b occ=%0d expected rdy=0 occ=2", bus.in_ready, bus.occ);
        end
        idle();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.in_ready, bus.occ, bus.PCSrcO, bus.RegWriteO, bus.MemtoRegO,
             bus.MemWriteO, bus.mem_we, bus.q1, bus.q2, bus.q3, bus.writeDataO, bus.WA3O} !==
            {4'b0100, 7'b0, {(4*W+WAW){1'b0}}}) begin
            tests_failed++;
            $display("FAIL rst_stall_vals: got status=%b we=%b q1=%h wa=%h expected 0100 we=000 q1=0 wa=0",
                     {bus.out_valid, bus.in_ready, bus.occ}, bus.mem_we, bus.q1, bus.WA3O);
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({bus.out_valid, bus.occ, bus.q1} !== {3'b000, {W{1'b0}}}) begin
                tests_failed++;
                $display("FAIL rst_stall_lost[%0d]: got v=%b occ=%0d q1=%h expected v=0 occ=0 q1=0",
                         i, bus.out_valid, bus.occ, bus.q1);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.flush = 1'b0;
        idle();
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_lane_mask();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
